// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, arbiter state and response tag types
package sprite_pkg;
    localparam int SPRITE_W = 40;
    localparam int SPRITE_H = 40;
    localparam int ADDR_W = 13;
    localparam int ID_W = 3;
    localparam int COORD_W = 6;
    localparam logic [23:0] TRANSPARENT = 24'hFF00FF;

    typedef enum logic {ARB, BURST} arb_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            oob;
        logic            last;
        logic            valid;
    } rsp_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker scanning from ptr+1 modulo N
module rr_pick #(
    parameter int N = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && valid[cand]) begin
                any = 1'b1;
                grant[cand] = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/note_sprite_fetch_arb.sv
// rtl/note_sprite_fetch_arb.sv - round-robin sprite ROM fetch arbiter with locked row bursts
module note_sprite_fetch_arb #(
    parameter int          NUM_REQ     = 5,
    parameter int          SPRITE_W    = sprite_pkg::SPRITE_W,
    parameter int          SPRITE_H    = sprite_pkg::SPRITE_H,
    parameter int          ADDR_W      = sprite_pkg::ADDR_W,
    parameter logic [23:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_burst,
    input  logic [NUM_REQ*6-1:0]   req_row,
    input  logic [NUM_REQ*6-1:0]   req_col,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [23:0]            rom_data,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic [23:0]            rsp_pixel,
    output logic                   rsp_transparent,
    output logic                   rsp_oob,
    output logic                   rsp_last
);
    import sprite_pkg::*;

    arb_state_t         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    burst_id;
    logic [COORD_W-1:0] burst_row;
    logic [COORD_W-1:0] col_cnt;
    logic [ADDR_W-1:0]  addr_hold;
    rsp_tag_t           tag_s1;

    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [COORD_W-1:0] g_row;
    logic [COORD_W-1:0] g_col;
    logic               g_oob;
    logic               enter_burst;

    logic               issue;
    logic [ID_W-1:0]    iss_id;
    logic [COORD_W-1:0] iss_row;
    logic [COORD_W-1:0] iss_col;
    logic               iss_oob;
    logic               iss_last;
    logic [ADDR_W-1:0]  addr_calc;

    // Arbitration only happens outside reset and outside a locked burst
    assign pick_valid = (Reset && state == ARB) ? req_valid : '0;

    rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
        .valid (pick_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = pick_grant;
    assign g_row = req_row[pick_idx*COORD_W +: COORD_W];
    assign g_col = req_col[pick_idx*COORD_W +: COORD_W];
    assign g_oob = (g_row >= COORD_W'(SPRITE_H)) || (g_col >= COORD_W'(SPRITE_W));
    assign enter_burst = pick_any && req_burst[pick_idx] && !g_oob &&
                         (g_col != COORD_W'(SPRITE_W - 1));

    always_comb begin
        issue = pick_any;
        iss_id = pick_idx;
        iss_row = g_row;
        iss_col = g_col;
        iss_oob = g_oob;
        iss_last = !enter_burst;
        if (state == BURST) begin
            issue = Reset;
            iss_id = burst_id;
            iss_row = burst_row;
            iss_col = col_cnt;
            iss_oob = 1'b0;
            iss_last = (col_cnt == COORD_W'(SPRITE_W - 1));
        end
    end

    assign addr_calc = ADDR_W'(iss_row) * ADDR_W'(SPRITE_W) + ADDR_W'(iss_col);
    assign rom_addr = issue ? addr_calc : addr_hold;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ARB;
            rr_ptr <= ID_W'(NUM_REQ - 1);
            burst_id <= '0;
            burst_row <= '0;
            col_cnt <= '0;
            addr_hold <= '0;
            tag_s1 <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_pixel <= '0;
            rsp_transparent <= 1'b0;
            rsp_oob <= 1'b0;
            rsp_last <= 1'b0;
        end else begin
            if (issue) begin
                addr_hold <= addr_calc;
            end
            tag_s1 <= '{id: iss_id, oob: iss_oob, last: iss_last, valid: issue};

            case (state)
                ARB: begin
                    if (pick_any) begin
                        rr_ptr <= pick_idx;
                        if (enter_burst) begin
                            state <= BURST;
                            burst_id <= pick_idx;
                            burst_row <= g_row;
                            col_cnt <= g_col + 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (iss_last) begin
                        state <= ARB;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase

            // Tag stage 1 lines up with the ROM's registered read data
            rsp_valid <= tag_s1.valid;
            if (tag_s1.valid) begin
                rsp_id <= tag_s1.id;
                rsp_oob <= tag_s1.oob;
                rsp_last <= tag_s1.last;
                rsp_pixel <= tag_s1.oob ? TRANSPARENT : rom_data;
                rsp_transparent <= tag_s1.oob || (rom_data == TRANSPARENT);
            end else begin
                rsp_id <= '0;
                rsp_oob <= 1'b0;
                rsp_last <= 1'b0;
                rsp_pixel <= '0;
                rsp_transparent <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_note_sprite_fetch_arb.sv
// tb/tb_note_sprite_fetch_arb.sv - directed self-checking bench for note_sprite_fetch_arb
module tb_note_sprite_fetch_arb;
    logic        Clk;
    logic        Reset;
    logic [4:0]  req_valid;
    logic [4:0]  req_burst;
    logic [29:0] req_row;
    logic [29:0] req_col;
    logic [4:0]  req_ready;
    logic [12:0] rom_addr;
    logic [23:0] rom_data;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [23:0] rsp_pixel;
    logic        rsp_transparent;
    logic        rsp_oob;
    logic        rsp_last;

    int n_tests = 0;
    int n_fail = 0;

    note_sprite_fetch_arb dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .req_valid       (req_valid),
        .req_burst       (req_burst),
        .req_row         (req_row),
        .req_col         (req_col),
        .req_ready       (req_ready),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_pixel       (rsp_pixel),
        .rsp_transparent (rsp_transparent),
        .rsp_oob         (rsp_oob),
        .rsp_last        (rsp_last)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM contents: word 77 holds the key colour, all others are distinct non-key values
    function automatic logic [23:0] rom_word(input logic [12:0] a);
        if (a == 13'd77) return 24'hFF00FF;
        return {11'h5A3, a};
    endfunction

    always @(posedge Clk) rom_data <= rom_word(rom_addr);

    task automatic set_lane(input int l, input logic v, input logic b, input int r, input int c);
        req_valid[l] = v;
        req_burst[l] = b;
        req_row[l*6 +: 6] = 6'(r);
        req_col[l*6 +: 6] = 6'(c);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b0;
        req_valid = '0;
        req_burst = '0;
        @(posedge Clk); #1;
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge Clk); #1;
        Reset = 1'b0;
        req_valid = 5'b11111;
        @(posedge Clk); #1;
        n_tests++;
        if (req_ready !== 5'b0) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=00000", req_ready);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_pixel !== 24'd0) begin
            n_fail++; $display("FAIL reset_rsp got v=%b id=%0d px=%h exp 0/0/0", rsp_valid, rsp_id, rsp_pixel);
        end
        n_tests++;
        if (rsp_transparent !== 1'b0 || rsp_oob !== 1'b0 || rsp_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got t=%b o=%b l=%b exp 0/0/0", rsp_transparent, rsp_oob, rsp_last);
        end
        n_tests++;
        if (rom_addr !== 13'd0) begin
            n_fail++; $display("FAIL reset_addr got=%0d exp=0", rom_addr);
        end
        req_valid = '0;
        Reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            if (k == 0) set_lane(2, 1'b1, 1'b0, 3, 5);
            else set_lane(2, 1'b0, 1'b0, 3, 5);
            #1;
            if (k == 0) begin
                n_tests++;
                if (req_ready !== 5'b00100 || rom_addr !== 13'd125) begin
                    n_fail++; $display("FAIL single_grant got rdy=%b addr=%0d exp 00100/125", req_ready, rom_addr);
                end
            end
            if (k == 1) begin
                n_tests++;
                if (rom_addr !== 13'd125 || rsp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL single_hold got addr=%0d v=%b exp 125/0", rom_addr, rsp_valid);
                end
            end
            if (k == 2) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_last !== 1'b1 ||
                    rsp_pixel !== rom_word(13'd125) || rsp_oob !== 1'b0 || rsp_transparent !== 1'b0) begin
                    n_fail++; $display("FAIL single_rsp got v=%b id=%0d l=%b px=%h o=%b t=%b exp 1/2/1/%h/0/0",
                        rsp_valid, rsp_id, rsp_last, rsp_pixel, rsp_oob, rsp_transparent, rom_word(13'd125));
                end
            end
        end
    endtask

    task automatic test_fairness();
        int exp_g;
        int exp_r;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            for (int l = 0; l < 5; l++) set_lane(l, k < 6, 1'b0, l, l);
            #1;
            exp_g = k % 5;
            n_tests++;
            if (k < 6 && (req_ready !== 5'(1 << exp_g) || rom_addr !== 13'(exp_g * 41))) begin
                n_fail++; $display("FAIL fair_grant k=%0d got rdy=%b addr=%0d exp lane %0d addr %0d",
                    k, req_ready, rom_addr, exp_g, exp_g * 41);
            end else if (k >= 6 && req_ready !== 5'b0) begin
                n_fail++; $display("FAIL fair_idle k=%0d got rdy=%b exp=00000", k, req_ready);
            end
            if (k >= 2) begin
                exp_r = (k - 2) % 5;
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'(exp_r) || rsp_pixel !== rom_word(13'(exp_r * 41))) begin
                    n_fail++; $display("FAIL fair_rsp k=%0d got v=%b id=%0d px=%h exp 1/%0d/%h",
                        k, rsp_valid, rsp_id, rsp_pixel, exp_r, rom_word(13'(exp_r * 41)));
                end
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int k = 0; k < 13; k++) begin
            @(posedge Clk); #1;
            set_lane(1, k == 0, 1'b1, 39, 30);
            set_lane(0, k >= 1 && k <= 10, 1'b0, 0, 1);
            #1;
            n_tests++;
            if (k <= 9 && (req_ready !== (k == 0 ? 5'b00010 : 5'b00000) || rom_addr !== 13'(1590 + k))) begin
                n_fail++; $display("FAIL burst_issue k=%0d got rdy=%b addr=%0d exp addr %0d", k, req_ready, rom_addr, 1590 + k);
            end else if (k == 10 && (req_ready !== 5'b00001 || rom_addr !== 13'd1)) begin
                n_fail++; $display("FAIL burst_next k=%0d got rdy=%b addr=%0d exp 00001/1", k, req_ready, rom_addr);
            end
            if (k >= 2 && k <= 11) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_last !== (k == 11) ||
                    rsp_pixel !== rom_word(13'(1588 + k))) begin
                    n_fail++; $display("FAIL burst_beat k=%0d got v=%b id=%0d l=%b px=%h exp 1/1/%b/%h",
                        k, rsp_valid, rsp_id, rsp_last, rsp_pixel, k == 11, rom_word(13'(1588 + k)));
                end
            end
            if (k == 12) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_last !== 1'b1) begin
                    n_fail++; $display("FAIL burst_after got v=%b id=%0d l=%b exp 1/0/1", rsp_valid, rsp_id, rsp_last);
                end
            end
        end
    endtask

    task automatic test_oob();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk); #1;
            set_lane(3, k == 0, 1'b1, 40, 0);
            set_lane(4, k == 1, 1'b0, 0, 0);
            set_lane(0, k == 2, 1'b0, 0, 40);
            #1;
            if (k == 1) begin
                n_tests++;
                if (req_ready !== 5'b10000) begin
                    n_fail++; $display("FAIL oob_noburst got rdy=%b exp=10000", req_ready);
                end
            end
            if (k == 2 || k == 4) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== (k == 2 ? 3'd3 : 3'd0) || rsp_oob !== 1'b1 ||
                    rsp_pixel !== 24'hFF00FF || rsp_transparent !== 1'b1 || rsp_last !== 1'b1) begin
                    n_fail++; $display("FAIL oob_rsp k=%0d got v=%b id=%0d o=%b px=%h t=%b l=%b exp oob beat",
                        k, rsp_valid, rsp_id, rsp_oob, rsp_pixel, rsp_transparent, rsp_last);
                end
            end
            if (k == 3) begin
                n_tests++;
                if (rsp_id !== 3'd4 || rsp_oob !== 1'b0 || rsp_pixel !== rom_word(13'd0)) begin
                    n_fail++; $display("FAIL oob_follow got id=%0d o=%b px=%h exp 4/0/%h", rsp_id, rsp_oob, rsp_pixel, rom_word(13'd0));
                end
            end
        end
    endtask

    task automatic test_transparent();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            set_lane(4, k == 0, 1'b0, 1, 37);
            #1;
            if (k == 2) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_transparent !== 1'b1 || rsp_oob !== 1'b0 || rsp_pixel !== 24'hFF00FF) begin
                    n_fail++; $display("FAIL transp got v=%b t=%b o=%b px=%h exp 1/1/0/ff00ff",
                        rsp_valid, rsp_transparent, rsp_oob, rsp_pixel);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            set_lane(2, k == 0, 1'b1, 5, 39);
            set_lane(3, k == 1, 1'b0, 2, 0);
            #1;
            if (k == 0 || k == 1) begin
                n_tests++;
                if (req_ready !== (k == 0 ? 5'b00100 : 5'b01000) || rom_addr !== (k == 0 ? 13'd239 : 13'd80)) begin
                    n_fail++; $display("FAIL b2b_grant k=%0d got rdy=%b addr=%0d", k, req_ready, rom_addr);
                end
            end else begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_id !== (k == 2 ? 3'd2 : 3'd3) ||
                    rsp_pixel !== rom_word(k == 2 ? 13'd239 : 13'd80)) begin
                    n_fail++; $display("FAIL b2b_rsp k=%0d got v=%b l=%b id=%0d px=%h", k, rsp_valid, rsp_last, rsp_id, rsp_pixel);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            set_lane(2, k == 0, 1'b1, 0, 0);
            set_lane(0, k >= 1 && k <= 5, 1'b0, 1, 1);
            set_lane(3, k >= 1 && k <= 6, 1'b0, 2, 2);
            Reset = !(k == 3 || k == 4);
            #1;
            if (k == 3 || k == 4) begin
                n_tests++;
                if (req_ready !== 5'b0) begin
                    n_fail++; $display("FAIL rst_burst_ready k=%0d got=%b exp=00000", k, req_ready);
                end
            end
            if (k >= 4 && k <= 6) begin
                n_tests++;
                if (rsp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rst_burst_stale k=%0d got v=%b exp=0", k, rsp_valid);
                end
            end
            if (k == 5) begin
                n_tests++;
                if (req_ready !== 5'b00001 || rom_addr !== 13'd41) begin
                    n_fail++; $display("FAIL rst_burst_first got rdy=%b addr=%0d exp 00001/41", req_ready, rom_addr);
                end
            end
            if (k == 6) begin
                n_tests++;
                if (req_ready !== 5'b01000) begin
                    n_fail++; $display("FAIL rst_burst_second got rdy=%b exp=01000", req_ready);
                end
            end
            if (k == 7) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_pixel !== rom_word(13'd41)) begin
                    n_fail++; $display("FAIL rst_burst_rsp got v=%b id=%0d px=%h exp 1/0/%h", rsp_valid, rsp_id, rsp_pixel, rom_word(13'd41));
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        req_valid = '0;
        req_burst = '0;
        req_row = '0;
        req_col = '0;
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_oob();
        test_transparent();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_sprite_fetch_arb.md
# note_sprite_fetch_arb

Round-robin fetch arbiter that shares one 40x40, 24-bit sprite frame ROM among several note-lane drawing requesters. It accepts (row, col) pixel requests, computes the linear ROM address, and drives the ROM read port. It returns each pixel, tagged with the requester id, on a shared response bus. It also supports locked row bursts, so one lane can stream a whole sprite row without interleaving. It sits between the per-lane note renderers and a single `frameRAM_<color>` instance.

## Interface
Parameters:
- NUM_REQ, 5, number of requesters (one per note lane)
- SPRITE_W, 40, sprite width in pixels
- SPRITE_H, 40, sprite height in pixels
- ADDR_W, 13, ROM address width
- TRANSPARENT, 24'hFF00FF, key colour flagged on responses

Ports:
- Clk  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_burst  in  NUM_REQ  request is a row burst (cols col..SPRITE_W-1)
- req_row  in  NUM_REQ*6  packed row per requester
- req_col  in  NUM_REQ*6  packed column per requester
- req_ready  out  NUM_REQ  one-hot grant; the request is consumed in this cycle
- rom_addr  out  ADDR_W  to ROM read_address
- rom_data  in  24  from ROM data_Out (1-cycle registered read)
- rsp_valid  out  1  response beat valid
- rsp_id  out  3  requester id of the beat
- rsp_pixel  out  24  pixel data
- rsp_transparent  out  1  rsp_pixel == TRANSPARENT
- rsp_oob  out  1  coordinate out of range; rsp_pixel forced to TRANSPARENT
- rsp_last  out  1  final beat of a burst, or any single beat

## Operation
- States: ARB and BURST.
- ARB:
  - Grant the first req_valid found scanning from rr_ptr+1 modulo NUM_REQ.
  - Assert req_ready for the grantee only.
  - Set rr_ptr to the grantee.
  - If req_burst is set and the coordinate is in range, latch owner, row and col, then go to BURST.
- BURST:
  - Issue one read per cycle for col_cnt = latched col+1 .. SPRITE_W-1.
  - req_ready stays low for all requesters.
  - Return to ARB after issuing col SPRITE_W-1.
  - The beat for col SPRITE_W-1 carries rsp_last=1.
  - A burst granted at col SPRITE_W-1 is a single beat.
- Address: rom_addr = row*SPRITE_W + col.
  - Compute at ADDR_W width with no truncation; the maximum is 1599.
  - With no grant, rom_addr holds its last value.
- Out of range (row>=SPRITE_H or col>=SPRITE_W):
  - Still granted; no burst is entered.
  - The beat returns rsp_oob=1, rsp_pixel=TRANSPARENT, rsp_transparent=1, rsp_last=1.
- The response bus has no backpressure; consumers must accept every beat.
- A requester must hold req_valid, req_row, req_col and req_burst stable until it sees req_ready.
- Deasserting req_valid during another lane's BURST is allowed and causes no grant.

## Timing
- Cycle N: grant, with req_ready combinational from req_valid and state.
  - rom_addr is driven combinationally from the granted coordinate (or the BURST counter).
- N+1: rom_data valid.
- N+2: rsp_* registered outputs valid. Issue-to-response latency is 2 cycles.
- Throughput is one beat per cycle, including ARB→BURST and BURST→ARB transitions with no bubble.
  - A BURST ending at cycle M allows a new ARB grant at M+1.
- An id/oob/last pipeline of 2 stages tracks each beat alongside the ROM.
- Reset asserted (Reset=0 at a posedge), including mid-burst:
  - state=ARB, rr_ptr=NUM_REQ-1, pipeline valid bits cleared.
  - rsp_valid=0, rsp_id=0, rsp_pixel=0, rsp_transparent=0, rsp_oob=0, rsp_last=0, rom_addr=0.
  - No beat issued before reset is returned after it.
  - While Reset=0, req_ready=0.
- Simultaneous requests resolve by round robin only; req_burst does not raise priority.

## Structure
- Shared package `sprite_pkg`: SPRITE_W, SPRITE_H, ADDR_W, TRANSPARENT, the `arb_state_t` enum {ARB, BURST}, and a `rsp_tag_t` struct {id, oob, last, valid}.
- One sub-module: `rr_pick`, a combinational round-robin priority picker (valid vector + pointer → one-hot grant + index).
- The ROM itself is external; this block does not instantiate it.

## Test plan
- Single request: lane 2 at row 3, col 5 → rom_addr 125 at N; rsp at N+2 with rsp_id=2, rsp_last=1, and the pixel matching ROM word 125.
- Fairness: all 5 lanes hold single requests → grants in order 0,1,2,3,4,0; rsp_id follows 2 cycles later with no gaps.
- Burst: lane 1 bursts row 39, col 30 → addresses 1590..1599 on consecutive cycles; 10 beats with id=1 and rsp_last only on the 10th; lane 0 waits until the cycle after.
- Out of range: row 40, col 0 → no burst entered; rsp_oob=1, rsp_pixel=FF00FF, rsp_transparent=1.
- Transparent detection: a ROM word equal to FF00FF → rsp_transparent=1, rsp_oob=0.
- Reset mid-burst at beat 4 → rsp_valid=0 from the next cycle with no stale beats; the first grant after release goes to lane 0.
